// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port router input stage.
// Buffers incoming flits in a circular FIFO, tracks the head flit's packet type and length,
// requests the arbiter when a header reaches the head, and drains the packet to the crossbar
// under grant until the tail leaves. Stray body/tail flits seen while idle are discarded.
module noc_input_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              req,
    input  logic              grant,
    output logic [DATA_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] ID_NONE = 3'b000;
    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_TAIL = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_input_buffer: DEPTH must be a power of two and at least 2");
    end
    if (DATA_W < 16) begin : g_bad_width
        $error("noc_input_buffer: DATA_W must be at least 16");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [11:0]       r_length;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_xfer;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [2:0]        w_head_id;
    logic              w_head_is_hdr;
    logic              w_head_is_tail;
    logic [1:0]        w_state_d;

    // FIFO status and head decode.
    always_comb begin
        w_empty        = (r_count == '0);
        w_head         = r_mem[r_rd_ptr];
        w_head_id      = w_empty ? ID_NONE : w_head[DATA_W-1 -: 3];
        w_head_is_hdr  = (w_head_id == ID_HEAD);
        w_head_is_tail = (w_head_id == ID_TAIL);
    end

    // Handshake decode: pushes, downstream transfers, stray-flit drops and the combined pop.
    always_comb begin
        // No full-bypass: a full FIFO refuses input even while popping.
        in_ready  = (r_count != CNT_W'(DEPTH));
        w_push    = in_valid && in_ready;
        out_valid = (r_state == ST_XFER) && grant && !w_empty;
        w_xfer    = out_valid && out_ready;
        // Anything other than a header at the head while idle is a stray flit.
        w_drop    = (r_state == ST_IDLE) && !w_empty && !w_head_is_hdr;
        w_pop     = w_xfer || w_drop;
    end

    // Packet-level FSM next-state.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_head_is_hdr) begin
                    w_state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    w_state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Only the tail leaving ends the packet; losing grant or running dry just stalls.
                if (w_xfer && w_head_is_tail) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_flit;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Length capture: reload whenever a header sits at the head, in any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_length <= '0;
        end else if (w_head_is_hdr) begin
            r_length <= w_head[11:0];
        end
    end

    // Output mapping.
    always_comb begin
        flit_id  = w_head_id;
        out_flit = w_head;
        length   = r_length;
        // Request is held from REQ entry through the whole transfer, including grant gaps.
        req      = (r_state == ST_REQ) || (r_state == ST_XFER);
        drop     = w_drop;
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: vector table plus hand sequences for reset and
// back-to-back packets.
module tb_noc_input_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        req;
    logic        grant;
    logic [31:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        drop;

    int checks   = 0;
    int failures = 0;

    noc_input_buffer #(
        .DEPTH  (4),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flit_id   (flit_id),
        .length    (length),
        .req       (req),
        .grant     (grant),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] flit;
        logic        gnt;
        logic        ordy;
        logic        e_irdy;
        logic [2:0]  e_id;
        logic [11:0] e_len;
        logic        e_req;
        logic        e_ov;
        logic        e_drop;
        logic [31:0] e_flit;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] f,
                                input logic g, input logic o, input logic irdy,
                                input logic [2:0] id, input logic [11:0] len,
                                input logic rq, input logic ov, input logic dr,
                                input logic [31:0] ef);
        vec_t v;
        v.rst_n = r;    v.iv = iv;      v.flit = f;    v.gnt = g;     v.ordy = o;
        v.e_irdy = irdy; v.e_id = id;   v.e_len = len; v.e_req = rq;  v.e_ov = ov;
        v.e_drop = dr;  v.e_flit = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs shortly after the rising edge, leave time to settle before sampling.
    task automatic step(input logic r, input logic iv, input logic [31:0] f,
                        input logic g, input logic o);
        @(posedge clk);
        #2;
        rst = r; in_valid = iv; in_flit = f; grant = g; out_ready = o;
        #2;
    endtask

    // Flit constants: id in [31:29], length in [11:0].
    localparam logic [31:0] H5 = 32'h2000_0005, B5 = 32'h4000_0B0B, T5 = 32'h8000_0C0C;
    localparam logic [31:0] H7 = 32'h2000_0007, BA = 32'h4000_00B1, BB = 32'h4000_00B2;
    localparam logic [31:0] TC = 32'h8000_00C1, BX = 32'h4000_00EE;
    localparam logic [31:0] BD = 32'h4000_00D1, TD = 32'h8000_00D2;
    localparam logic [31:0] H9 = 32'h2000_0009, B1 = 32'h4000_0001, B2 = 32'h4000_0002;
    localparam logic [31:0] T9 = 32'h8000_0003, HAB = 32'h2000_00AB;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pk [6];
        logic [31:0] got [$];
        logic        exp_req [12];

        rst = 1'b0; in_valid = 1'b0; in_flit = '0; grant = 1'b0; out_ready = 1'b0;

        //            rst iv flit g  o  | irdy id len     req ov dr head
        // Reset state.
        tbl[0]  = mk(1, 0, 0,  0, 0,  1, 0, 12'h000, 0, 0, 0, 0);
        // Single packet H/B/T with grant and out_ready held high.
        tbl[1]  = mk(1, 1, H5, 1, 1,  1, 0, 12'h000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, B5, 1, 1,  1, 1, 12'h000, 0, 0, 0, H5);
        tbl[3]  = mk(1, 1, T5, 1, 1,  1, 1, 12'h005, 1, 0, 0, H5);
        tbl[4]  = mk(1, 0, 0,  1, 1,  1, 1, 12'h005, 1, 1, 0, H5);
        tbl[5]  = mk(1, 0, 0,  1, 1,  1, 2, 12'h005, 1, 1, 0, B5);
        tbl[6]  = mk(1, 0, 0,  1, 1,  1, 4, 12'h005, 1, 1, 0, T5);
        tbl[7]  = mk(1, 0, 0,  1, 1,  1, 0, 12'h005, 0, 0, 0, 0);
        // Fill to DEPTH with out_ready low; 5th flit refused; one pop reopens in_ready.
        tbl[8]  = mk(1, 1, H7, 0, 0,  1, 0, 12'h005, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, BA, 0, 0,  1, 1, 12'h005, 0, 0, 0, H7);
        tbl[10] = mk(1, 1, BB, 0, 0,  1, 1, 12'h007, 1, 0, 0, H7);
        tbl[11] = mk(1, 1, TC, 0, 0,  1, 1, 12'h007, 1, 0, 0, H7);
        tbl[12] = mk(1, 1, BX, 0, 0,  0, 1, 12'h007, 1, 0, 0, H7);
        tbl[13] = mk(1, 0, 0,  1, 0,  0, 1, 12'h007, 1, 0, 0, H7);
        tbl[14] = mk(1, 0, 0,  1, 1,  0, 1, 12'h007, 1, 1, 0, H7);
        tbl[15] = mk(1, 0, 0,  0, 0,  1, 2, 12'h007, 1, 0, 0, BA);
        tbl[16] = mk(1, 0, 0,  1, 1,  1, 2, 12'h007, 1, 1, 0, BA);
        tbl[17] = mk(1, 0, 0,  1, 1,  1, 2, 12'h007, 1, 1, 0, BB);
        tbl[18] = mk(1, 0, 0,  1, 1,  1, 4, 12'h007, 1, 1, 0, TC);
        tbl[19] = mk(1, 0, 0,  0, 0,  1, 0, 12'h007, 0, 0, 0, 0);
        // Stray body then tail: two drop pulses, no request.
        tbl[20] = mk(1, 1, BD, 0, 0,  1, 0, 12'h007, 0, 0, 0, 0);
        tbl[21] = mk(1, 1, TD, 0, 0,  1, 2, 12'h007, 0, 0, 1, BD);
        tbl[22] = mk(1, 0, 0,  0, 0,  1, 4, 12'h007, 0, 0, 1, TD);
        tbl[23] = mk(1, 0, 0,  0, 0,  1, 0, 12'h007, 0, 0, 0, 0);
        // Grant withdrawn for 3 cycles mid-packet, then resumes at B2.
        tbl[24] = mk(1, 1, H9, 0, 1,  1, 0, 12'h007, 0, 0, 0, 0);
        tbl[25] = mk(1, 1, B1, 0, 1,  1, 1, 12'h007, 0, 0, 0, H9);
        tbl[26] = mk(1, 1, B2, 1, 1,  1, 1, 12'h009, 1, 0, 0, H9);
        tbl[27] = mk(1, 1, T9, 1, 1,  1, 1, 12'h009, 1, 1, 0, H9);
        tbl[28] = mk(1, 0, 0,  1, 1,  1, 2, 12'h009, 1, 1, 0, B1);
        tbl[29] = mk(1, 0, 0,  0, 1,  1, 2, 12'h009, 1, 0, 0, B2);
        tbl[30] = mk(1, 0, 0,  0, 1,  1, 2, 12'h009, 1, 0, 0, B2);
        tbl[31] = mk(1, 0, 0,  0, 1,  1, 2, 12'h009, 1, 0, 0, B2);
        tbl[32] = mk(1, 0, 0,  1, 1,  1, 2, 12'h009, 1, 1, 0, B2);
        tbl[33] = mk(1, 0, 0,  1, 1,  1, 4, 12'h009, 1, 1, 0, T9);
        tbl[34] = mk(1, 0, 0,  0, 0,  1, 0, 12'h009, 0, 0, 0, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst_n, tbl[i].iv, tbl[i].flit, tbl[i].gnt, tbl[i].ordy);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            chk($sformatf("v%0d flit_id", i), 32'(flit_id), 32'(tbl[i].e_id));
            chk($sformatf("v%0d length", i), 32'(length), 32'(tbl[i].e_len));
            chk($sformatf("v%0d req", i), 32'(req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d drop", i), 32'(drop), 32'(tbl[i].e_drop));
            if (tbl[i].e_id != 3'b000) begin
                chk($sformatf("v%0d out_flit", i), out_flit, tbl[i].e_flit);
            end
        end

        // Reset mid-packet: enter XFER with flits buffered, then reset.
        step(1, 1, HAB, 1, 0);
        step(1, 1, B1,  1, 0);
        step(1, 1, B2,  1, 0);
        step(1, 0, 0,   1, 0);
        chk("rst_pre req", 32'(req), 32'd1);
        chk("rst_pre out_valid", 32'(out_valid), 32'd1);
        chk("rst_pre length", 32'(length), 32'h0AB);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        chk("rst_post flit_id", 32'(flit_id), 32'd0);
        chk("rst_post req", 32'(req), 32'd0);
        chk("rst_post length", 32'(length), 32'd0);
        chk("rst_post in_ready", 32'(in_ready), 32'd1);
        chk("rst_post out_valid", 32'(out_valid), 32'd0);
        chk("rst_post drop", 32'(drop), 32'd0);

        // Back-to-back packets, length 3 then 10, grant and out_ready held high.
        pk[0] = 32'h2000_0003; pk[1] = 32'h4000_0011; pk[2] = 32'h8000_0012;
        pk[3] = 32'h2000_000A; pk[4] = 32'h4000_0021; pk[5] = 32'h8000_0022;
        exp_req[0] = 0; exp_req[1] = 0; exp_req[2]  = 1; exp_req[3]  = 1;
        exp_req[4] = 1; exp_req[5] = 1; exp_req[6]  = 0; exp_req[7]  = 1;
        exp_req[8] = 1; exp_req[9] = 1; exp_req[10] = 1; exp_req[11] = 0;
        for (int c = 0; c < 12; c++) begin
            step(1, (c < 6), (c < 6) ? pk[c] : 32'h0, 1, 1);
            chk($sformatf("b2b c%0d req", c), 32'(req), 32'(exp_req[c]));
            if (c < 6) begin
                chk($sformatf("b2b c%0d in_ready", c), 32'(in_ready), 32'd1);
            end
            if (c == 6) begin
                chk("b2b length first", 32'(length), 32'h003);
            end
            if (c == 7) begin
                chk("b2b length second", 32'(length), 32'h00A);
            end
            if (out_valid === 1'b1) begin
                got.push_back(out_flit);
            end
        end
        chk("b2b flit count", got.size(), 32'd6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            chk($sformatf("b2b flit %0d", i), got[i], pk[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
